seq_shift_unit: RTL and testbench
=================================

SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, the datapath width.
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port Start  input  1  request to begin one shift operation; sampled only in IDLE.
REQ-005 SHALL have port Src1  input  XLEN  operand to be shifted, captured on the accepted Start edge.
REQ-006 SHALL have port Src2  input  5  shift amount N (0-31), captured on the accepted Start edge.
REQ-007 SHALL have port funct3_2  input  1  op select bit, captured on the accepted Start edge.
REQ-008 SHALL have port funct7_5  input  1  op select bit, captured on the accepted Start edge.
REQ-009 SHALL have port Busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port Done  output  1  single-cycle completion pulse.
REQ-011 SHALL have port Result  output  XLEN  registered shift result.

Function
REQ-012 SHALL decode {funct7_5,funct3_2}: 00 = SLL, 01 = SRL, 11 = SRA, 10 = invalid.
REQ-013 SHALL implement exactly three states: IDLE, SHIFT, DONE.
REQ-014 SHALL, in IDLE with Start=1 at an edge (edge 0), latch Src1 into an internal work register, N into a 5-bit down-counter, and the op into a register.
REQ-015 SHALL go from IDLE to DONE at edge 0 when N=0 or op is invalid; otherwise it SHALL go to SHIFT.
REQ-016 SHALL, at each edge in SHIFT, shift the work register by exactly one bit and decrement the counter.
REQ-017 SHALL fill with 0 at bit 0 for SLL, with 0 at bit XLEN-1 for SRL, and with the captured Src1[XLEN-1] for SRA.
REQ-018 SHALL go from SHIFT to DONE at the edge where the counter goes 1 -> 0, which is edge N.
REQ-019 SHALL assert Done only in DONE, giving Done in the cycle after edge N (after edge 0 when N=0 or op is invalid).
REQ-020 SHALL go from DONE to IDLE unconditionally on the next edge.
REQ-021 SHALL load Result on the edge entering DONE: the final work value for a valid op, Src1 for N=0, and 0 for an invalid op.
REQ-022 SHALL hold Result unchanged at all other times, including throughout SHIFT.
REQ-023 SHALL ignore Start in SHIFT and DONE, with no queuing and no change to the latched operands.
REQ-024 SHALL ignore changes on Src1, Src2, funct3_2 and funct7_5 after edge 0.
REQ-025 SHALL accept a Start in the first IDLE cycle after DONE (back-to-back throughput of N+2 cycles per operation).

Reset
REQ-026 SHALL, while RST=1 and independent of CLK, force state IDLE, Busy 0, Done 0, Result 0, counter 0 and work register 0.
REQ-027 SHALL abort any operation in progress when RST asserts mid-operation, with no Done pulse and Result 0.
REQ-028 SHALL accept Start at the first rising edge after RST deasserts.

Verification
REQ-029 SHALL cover: SRA, Src1=0x80000000, N=4 -> Busy for 5 cycles, Done after edge 4, Result=0xF8000000.
REQ-030 SHALL cover: SLL, Src1=0x00000001, N=31 -> Done after edge 31, Result=0x80000000; SRL, Src1=0xF0000000, N=28 -> Result=0x0000000F.
REQ-031 SHALL cover: N=0, SRL, Src1=0x12345678 -> Done in the cycle after edge 0, Result=0x12345678; op 10, Src1=0xFFFFFFFF, N=5 -> Done after edge 0, Result=0.
REQ-032 SHALL cover: Start re-pulsed with Src1=0xDEADBEEF during a SRL by 8 of 0x0000FF00 -> the second Start is ignored, Result=0x000000FF, and exactly one Done pulse occurs.
REQ-033 SHALL cover: RST asserted at edge 3 of a SLL by 10 -> Busy, Done and Result are 0 immediately, no Done follows, and a new Start is accepted after release.
REQ-034 SHALL cover: back-to-back SRA by 1 of 0xFFFFFFFE, then SLL by 2 of 0x1 with Start issued in the first IDLE cycle -> Results 0xFFFFFFFF then 0x00000004, with two Done pulses 4 cycles apart.

Source files
------------

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: moves the operand one bit per clock for SLL/SRL/SRA.
// N=0 and invalid op codes finish straight from IDLE.
module seq_shift_unit #(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            Start,
   input  logic [XLEN-1:0] Src1,
   input  logic [4:0]      Src2,
   input  logic            funct3_2,
   input  logic            funct7_5,
   output logic            Busy,
   output logic            Done,
   output logic [XLEN-1:0] Result
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b11;
   localparam logic [1:0] OP_BAD = 2'b10;

   state_t          state_q, state_d;
   logic [XLEN-1:0] work_q, work_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [1:0]      op_q, op_d;
   logic [1:0]      op_in;
   logic            quick_done;
   logic [XLEN-1:0] work_step;

   assign op_in      = {funct7_5, funct3_2};
   assign quick_done = (Src2 == 5'd0) || (op_in == OP_BAD);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (Start) state_d = quick_done ? S_DONE : S_SHIFT;
         S_SHIFT: if (cnt_q == 5'd1) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      Busy = (state_q != S_IDLE);
      Done = (state_q == S_DONE);
   end

   // The MSB of the work register still holds the captured sign for SRA.
   always_comb begin
      case (op_q)
         OP_SLL:  work_step = {work_q[XLEN-2:0], 1'b0};
         OP_SRL:  work_step = {1'b0, work_q[XLEN-1:1]};
         OP_SRA:  work_step = {work_q[XLEN-1], work_q[XLEN-1:1]};
         default: work_step = work_q;
      endcase
   end

   always_comb begin
      work_d   = work_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               work_d = Src1;
               cnt_d  = Src2;
               op_d   = op_in;
               if (op_in == OP_BAD) begin
                  result_d = '0;
               end else if (Src2 == 5'd0) begin
                  result_d = Src1;
               end
            end
         end
         S_SHIFT: begin
            work_d = work_step;
            cnt_d  = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               result_d = work_step;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         work_q   <= '0;
         cnt_q    <= '0;
         op_q     <= OP_SLL;
         result_q <= '0;
      end else begin
         work_q   <= work_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         result_q <= result_d;
      end
   end

   assign Result = result_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Randomized and directed bench for seq_shift_unit against an arithmetic
// shift model with cycle-exact Busy/Done/Result expectations.
module tb_seq_shift_unit;
   localparam int XLEN = 32;

   logic            CLK;
   logic            RST;
   logic            Start;
   logic [XLEN-1:0] Src1;
   logic [4:0]      Src2;
   logic            funct3_2;
   logic            funct7_5;
   logic            Busy;
   logic            Done;
   logic [XLEN-1:0] Result;

   int              n_checks = 0;
   int              n_pass   = 0;
   logic [XLEN-1:0] model_result;

   seq_shift_unit #(.XLEN(XLEN)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .Start    (Start),
      .Src1     (Src1),
      .Src2     (Src2),
      .funct3_2 (funct3_2),
      .funct7_5 (funct7_5),
      .Busy     (Busy),
      .Done     (Done),
      .Result   (Result)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // Op codes are {funct7_5, funct3_2}: 00 SLL, 01 SRL, 11 SRA, 10 invalid.
   function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                             input int n);
      logic signed [31:0] s;
      s = a;
      case (op)
         2'b00:   return a << n;
         2'b01:   return a >> n;
         2'b11:   return s >>> n;
         default: return 32'h0;
      endcase
   endfunction

   // Called on a negedge with the DUT in IDLE; returns on the negedge after
   // DONE->IDLE so a following call issues Start in the first IDLE cycle.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [4:0] n, input bit garbage);
      logic [31:0] exp_res;
      int          last;
      exp_res = ref_shift(op, a, int'(n));
      last    = (n == 5'd0 || op == 2'b10) ? 0 : int'(n);
      check("idle_busy", 32'(Busy), 32'd0);
      Start = 1'b1;
      Src1  = a;
      Src2  = n;
      {funct7_5, funct3_2} = op;
      for (int k = 0; k <= last + 1; k++) begin
         @(negedge CLK);
         if (k < last) begin
            check("shift_busy", 32'(Busy), 32'd1);
            check("shift_done", 32'(Done), 32'd0);
            check("shift_hold", Result, model_result);
         end else if (k == last) begin
            check("done_busy", 32'(Busy), 32'd1);
            check("done_pulse", 32'(Done), 32'd1);
            check("result", Result, exp_res);
         end else begin
            check("post_busy", 32'(Busy), 32'd0);
            check("post_done", 32'(Done), 32'd0);
            check("post_result", Result, exp_res);
         end
         if (garbage && k <= last) begin
            Start = 1'b1;
            Src1  = 32'hDEADBEEF;
            Src2  = ~n;
            {funct7_5, funct3_2} = ~op;
         end else begin
            Start = 1'b0;
            Src1  = $urandom;
            Src2  = 5'($urandom_range(0, 31));
            {funct7_5, funct3_2} = 2'($urandom_range(0, 3));
         end
      end
      model_result = exp_res;
      $display("op=%b src1=%h n=%0d garbage=%0d result=%h expected=%h",
               op, a, n, garbage, Result, exp_res);
   endtask

   initial begin
      logic [1:0]  op;
      logic [4:0]  n;
      logic [31:0] a;
      RST      = 1'b1;
      Start    = 1'b0;
      Src1     = '0;
      Src2     = '0;
      funct3_2 = 1'b0;
      funct7_5 = 1'b0;
      model_result = '0;
      @(negedge CLK);
      @(negedge CLK);
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_result", Result, 32'd0);
      RST = 1'b0;

      // Start at the first edge after reset release, then back-to-back ops.
      run_op(2'b01, 32'h12345678, 5'd0, 1'b0);
      run_op(2'b11, 32'h80000000, 5'd4, 1'b0);
      run_op(2'b00, 32'h00000001, 5'd31, 1'b0);
      run_op(2'b01, 32'hF0000000, 5'd28, 1'b0);
      run_op(2'b10, 32'hFFFFFFFF, 5'd5, 1'b0);
      run_op(2'b01, 32'h0000FF00, 5'd8, 1'b1);
      run_op(2'b11, 32'hFFFFFFFE, 5'd1, 1'b0);
      run_op(2'b00, 32'h00000001, 5'd2, 1'b0);

      // Abort a SLL by 10 just after edge 3.
      Start = 1'b1;
      Src1  = 32'h00000003;
      Src2  = 5'd10;
      {funct7_5, funct3_2} = 2'b00;
      @(negedge CLK);
      Start = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      check("pre_abort_busy", 32'(Busy), 32'd1);
      @(posedge CLK);
      #1 RST = 1'b1;
      #1;
      check("abort_busy", 32'(Busy), 32'd0);
      check("abort_done", 32'(Done), 32'd0);
      check("abort_result", Result, 32'd0);
      model_result = '0;
      @(negedge CLK);
      RST = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         check("abort_no_done", 32'(Done), 32'd0);
         check("abort_idle", 32'(Busy), 32'd0);
      end
      $display("reset abort of SLL by 10 at edge 3 result=%h", Result);
      run_op(2'b00, 32'h0000000F, 5'd3, 1'b0);

      for (int t = 0; t < 30; t++) begin
         op = 2'($urandom_range(0, 3));
         n  = 5'($urandom_range(0, 31));
         a  = $urandom;
         if (op == 2'b10 && n == 5'd0) begin
            n = 5'd1;
         end
         run_op(op, a, n, 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
